// File: rtl/sigmoid_index_search.sv
// sigmoid_index_search
//
// Reverse lookup for the activation table. The block holds a writable table of
// DEPTH FP16 entries. For a presented FP16 value it returns the index of the
// largest entry that does not exceed that value. The table is scanned one
// entry per clock, so every search takes exactly DEPTH cycles.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   wr_en      table write strobe (honoured only while wr_ready is high)
//   wr_addr    table write address; addresses >= DEPTH are dropped
//   wr_data    table write data
//   wr_ready   writes are accepted (IDLE, out of reset)
//   in_valid   search value valid
//   in_ready   block can accept a search value
//   in_value   FP16 value to search for
//   out_valid  result valid; result fields held until out_ready
//   out_ready  downstream accepts the result
//   out_index  selected table index (0 when out_none)
//   out_hit    selected entry equals the search value exactly
//   out_none   no table entry is <= the search value
module sigmoid_index_search #(
    parameter int DEPTH  = 10,
    parameter int IDX_W  = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_hit,
    output logic              out_none
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] table_q [DEPTH];

    // Search context
    logic [DATA_W-1:0] x_key;
    logic [IDX_W-1:0]  scan_idx;
    logic              best_valid;
    logic [IDX_W-1:0]  best_idx;
    logic [DATA_W-1:0] best_key;

    // Combinational view of the entry under the scan pointer
    logic [DATA_W-1:0] entry_sel;
    logic [DATA_W-1:0] entry_key;
    logic              take;
    logic              nxt_best_valid;
    logic [IDX_W-1:0]  nxt_best_idx;
    logic [DATA_W-1:0] nxt_best_key;
    logic              scan_last;

    // Maps an FP16 bit pattern to an unsigned key with the same ordering as
    // the real numbers it encodes. Positives get the top bit set so they sit
    // above every negative; negatives are inverted so larger magnitudes sort
    // lower. -0 is folded onto +0 so both zeros share one key.
    function automatic logic [DATA_W-1:0] order_key(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] m;
        m = v;
        if (m == {1'b1, {(DATA_W-1){1'b0}}}) begin
            m = '0;
        end
        if (!m[DATA_W-1]) begin
            order_key = {1'b1, m[DATA_W-2:0]};
        end else begin
            order_key = ~m;
        end
    endfunction

    // Power-on contents of the activation table
    function automatic logic [DATA_W-1:0] default_entry(input int unsigned i);
        logic [15:0] e;
        case (i)
            0:       e = 16'h5800;
            1:       e = 16'h2000;
            2:       e = 16'h2000;
            3:       e = 16'h3000;
            4:       e = 16'h2800;
            5:       e = 16'h2C00;
            6:       e = 16'h3000;
            7:       e = 16'h3000;
            8:       e = 16'h3400;
            9:       e = 16'h3800;
            default: e = 16'h0000;
        endcase
        default_entry = DATA_W'(e);
    endfunction

    // Table read through an explicit compare-mux so that the pointer width
    // never has to match the table depth.
    always_comb begin
        entry_sel = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                entry_sel = table_q[i];
            end
        end
        entry_key = order_key(entry_sel);

        // Strict '>' against the current best keeps the lowest index on ties.
        take = (entry_key <= x_key) && (!best_valid || (entry_key > best_key));

        nxt_best_valid = best_valid | take;
        nxt_best_idx   = take ? scan_idx  : best_idx;
        nxt_best_key   = take ? entry_key : best_key;

        scan_last = (scan_idx == IDX_W'(DEPTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            wr_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_index  <= '0;
            out_hit    <= 1'b0;
            out_none   <= 1'b0;
            x_key      <= '0;
            scan_idx   <= '0;
            best_valid <= 1'b0;
            best_idx   <= '0;
            best_key   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                table_q[i] <= default_entry(i);
            end
        end else begin
            case (state)
                IDLE: begin
                    // Ready flags are registered, so the first cycle after
                    // reset release still shows them low.
                    in_ready <= 1'b1;
                    wr_ready <= 1'b1;

                    if (wr_en && wr_ready) begin
                        for (int unsigned i = 0; i < DEPTH; i++) begin
                            if (wr_addr == IDX_W'(i)) begin
                                table_q[i] <= wr_data;
                            end
                        end
                    end

                    // A write on the accept edge lands before the first scan
                    // cycle, so the search sees it.
                    if (in_valid && in_ready) begin
                        x_key      <= order_key(in_value);
                        scan_idx   <= '0;
                        best_valid <= 1'b0;
                        best_idx   <= '0;
                        best_key   <= '0;
                        in_ready   <= 1'b0;
                        wr_ready   <= 1'b0;
                        state      <= SCAN;
                    end
                end

                SCAN: begin
                    best_valid <= nxt_best_valid;
                    best_idx   <= nxt_best_idx;
                    best_key   <= nxt_best_key;
                    scan_idx   <= scan_idx + 1'b1;

                    // Result is formed from the post-update best so the
                    // final entry is included without an extra cycle.
                    if (scan_last) begin
                        out_valid <= 1'b1;
                        out_none  <= !nxt_best_valid;
                        out_index <= nxt_best_valid ? nxt_best_idx : '0;
                        out_hit   <= nxt_best_valid && (nxt_best_key == x_key);
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        wr_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sigmoid_index_search.sv
// Directed bench for sigmoid_index_search (DEPTH=10). Expected indices are
// worked out by hand from the default table:
//   0:5800 1:2000 2:2000 3:3000 4:2800 5:2C00 6:3000 7:3000 8:3400 9:3800
module tb_sigmoid_index_search;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic        out_hit;
    logic        out_none;

    int n_checks = 0;
    int n_fail   = 0;

    sigmoid_index_search #(
        .DEPTH (10),
        .IDX_W (5),
        .DATA_W(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_index(out_index),
        .out_hit  (out_hit),
        .out_none (out_none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for in_ready, then presents v for the accept edge.
    task automatic start_search(input logic [15:0] v);
        int n;
        n = 0;
        in_value = v;
        in_valid = 1'b1;
        while (!in_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Returns the cycle index (accept cycle = 0) in which out_valid is seen.
    task automatic wait_result(output int lat);
        int n;
        n = 1;
        while (!out_valid && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check("result_valid", 32'(out_valid), 32'd1);
        lat = n;
    endtask

    task automatic search(input string tag, input logic [15:0] v,
                          input logic [4:0] ei, input logic eh, input logic en);
        int lat;
        out_ready = 1'b1;
        start_search(v);
        wait_result(lat);
        check({tag, "_latency"}, 32'(lat), 32'd11);
        check({tag, "_index"}, 32'(out_index), 32'(ei));
        check({tag, "_hit"}, 32'(out_hit), 32'(eh));
        check({tag, "_none"}, 32'(out_none), 32'(en));
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic table_write(input logic [4:0] a, input logic [15:0] d);
        int n;
        n = 0;
        while (!wr_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check("write_ready", 32'(wr_ready), 32'd1);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    initial begin
        int lat;
        logic seen_valid;

        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        in_valid  = 1'b0;
        in_value  = '0;
        out_ready = 1'b1;

        // Reset state
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_out_hit", 32'(out_hit), 32'd0);
        check("rst_out_none", 32'(out_none), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Default table searches
        search("s3000", 16'h3000, 5'd3, 1'b1, 1'b0);   // ties at 6,7 lose to 3
        search("s3A00", 16'h3A00, 5'd9, 1'b0, 1'b0);   // 0x3800 is the largest below
        search("s7C00", 16'h7C00, 5'd0, 1'b0, 1'b0);   // +Inf above 0x5800
        search("s5800", 16'h5800, 5'd0, 1'b1, 1'b0);
        search("s0000", 16'h0000, 5'd0, 1'b0, 1'b1);
        search("s8000", 16'h8000, 5'd0, 1'b0, 1'b1);   // -0 behaves as +0
        search("sBC00", 16'hBC00, 5'd0, 1'b0, 1'b1);   // -1.0

        // Backpressure: result held while out_ready is low
        out_ready = 1'b0;
        start_search(16'h2C00);
        wait_result(lat);
        check("bp_latency", 32'(lat), 32'd11);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid_held", 32'(out_valid), 32'd1);
            check("bp_index_held", 32'(out_index), 32'd5);
            check("bp_hit_held", 32'(out_hit), 32'd1);
            check("bp_none_held", 32'(out_none), 32'd0);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_drop", 32'(out_valid), 32'd0);
        check("bp_in_ready_rise", 32'(in_ready), 32'd1);

        // IDLE write to entry 9
        table_write(5'd9, 16'h3C00);
        search("w9_3C00", 16'h3C00, 5'd9, 1'b1, 1'b0);

        // Out-of-range write must not land anywhere: 0x3A00 still has no exact match
        table_write(5'd12, 16'h3A00);
        search("w12_3A00", 16'h3A00, 5'd8, 1'b0, 1'b0);

        // Write during SCAN is dropped
        out_ready = 1'b1;
        start_search(16'h3B00);
        @(posedge clk); #1;
        check("scan_wr_ready_low", 32'(wr_ready), 32'd0);
        wr_addr = 5'd3;
        wr_data = 16'h3B00;
        wr_en   = 1'b1;
        @(posedge clk); #1;
        wr_en   = 1'b0;
        wait_result(lat);
        check("scanwr_index", 32'(out_index), 32'd8);
        check("scanwr_hit", 32'(out_hit), 32'd0);
        @(posedge clk); #1;
        search("scanwr_after", 16'h3B00, 5'd8, 1'b0, 1'b0);

        // Reset in scan cycle 4 aborts the search
        start_search(16'h3400);
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        seen_valid = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | out_valid;
        end
        check("midrst_no_stale", 32'(seen_valid), 32'd0);
        search("post_rst_3400", 16'h3400, 5'd8, 1'b1, 1'b0);
        search("post_rst_3A00", 16'h3A00, 5'd9, 1'b0, 1'b0);   // entry 9 back to 0x3800

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sigmoid_index_search.md
Name: sigmoid_index_search

Overview:
- Inverse of the activation lookup table: takes a 16-bit FP16 value and returns the 5-bit table index whose entry is the largest value not exceeding the input.
- The lookup table maps index to value; this block maps value to index.
- Holds a writable 10-entry FP16 table. It scans the table sequentially, one entry per clock, with a valid/ready handshake on both input and output.
- Used by the CNN activation stage to quantize layer outputs back into table indices.

Parameters:
- DEPTH, 10, number of table entries scanned (1..32).
- IDX_W, 5, index width.
- DATA_W, 16, entry/input width (FP16 bit layout).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  IDX_W  table write address.
- wr_data  in  DATA_W  table write data.
- wr_ready  out  1  high when writes are accepted (state IDLE, not in reset).
- in_valid  in  1  input value valid.
- in_ready  out  1  block can accept a value.
- in_value  in  DATA_W  FP16 value to search.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_index  out  IDX_W  selected index.
- out_hit  out  1  selected entry equals the input exactly.
- out_none  out  1  no entry is <= the input.

Behaviour:
- Reset: all interface outputs below are sampled the cycle after reset is asserted.
  - Outputs: in_ready=0, wr_ready=0, out_valid=0, out_index=0, out_hit=0, out_none=0.
  - FSM goes to IDLE.
  - Table loads defaults, entries 0..9: 0x5800, 0x2000, 0x2000, 0x3000, 0x2800, 0x2C00, 0x3000, 0x3000, 0x3400, 0x3800.
  - Entries at or above 10 (when DEPTH>10) reset to 0x0000.
  - Reset asserted mid-scan or mid-output aborts the operation. No result is produced.
- Ordering key:
  - sign=0: key = {1'b1, v[14:0]}.
  - sign=1: key = ~v.
  - -0 (0x8000) is mapped to +0 before keying.
  - Keys compare unsigned. NaN/Inf get no special handling; they order by key.
- FSM IDLE -> SCAN -> DONE -> IDLE.
- IDLE:
  - in_ready=1, wr_ready=1.
  - Write: wr_en with wr_addr<DEPTH writes the entry at the clock edge. wr_addr>=DEPTH is dropped.
  - Accept: in_valid&in_ready latches in_value, clears the best-found state, sets the scan counter to 0, and moves to SCAN.
  - Write and accept on the same edge: both happen; the scan sees the new entry.
- SCAN:
  - in_ready=0, wr_ready=0. wr_en is ignored (dropped, no effect).
  - Each cycle compares entry[i] with the latched value.
  - If key(entry) <= key(x) and (no best yet, or key(entry) > key(best)), then best = i.
  - Strict '>' means ties go to the lowest index.
  - Counter increments. After i=DEPTH-1, go to DONE.
  - Fixed length of DEPTH cycles; no early exit.
- DONE:
  - out_valid=1. out_index, out_hit and out_none are stable and held while out_ready=0.
  - out_none=1 and out_index=0 if no entry qualified.
  - out_hit=1 iff key(entry[best]) == key(x).
  - out_valid&out_ready returns to IDLE. out_valid drops next cycle; in_ready rises next cycle.
  - No input is accepted in DONE, so there is no same-cycle out/in overlap.
- Latency:
  - Accept edge at cycle N; out_valid first high in cycle N+DEPTH+1 (cycle 11 after accept for DEPTH=10).
  - Throughput: one search per DEPTH+2 cycles with out_ready held high.

Test Plan:
- After reset: in_value=0x3000 -> out_index=3, out_hit=1, out_none=0 (ties at 6, 7 ignored); out_valid exactly 11 cycles after accept.
- in_value=0x3A00 (0.75) -> out_index=9, hit=0. in_value=0x7C00 (+Inf) -> out_index=0, hit=0. in_value=0x5800 -> out_index=0, hit=1.
- in_value=0x0000, 0x8000, 0xBC00 -> each returns out_none=1, out_index=0, hit=0.
- Write entry 9 = 0x3C00 in IDLE, then in_value=0x3C00 -> out_index=9, hit=1. Write addr 12 -> no effect. Write during SCAN -> dropped; table readback via searches is unchanged.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and outputs held, in_ready=0. Release -> out_valid drops next cycle, in_ready rises.
- Assert reset at scan cycle 4, then release, then search 0x3400 -> no stale result; out_index=8, hit=1 with the default table restored.
